uart_rx_core: RTL



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_core_if.sv | 14 +
 rtl/uart_baud_tick.sv | 18 +
 rtl/uart_rx_core.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and board defaults shared by the UART receiver and transmitter.
package uart_pkg;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD = 9600;
  localparam int OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: byte handshake and status flags between the UART receiver and its consumer.
// UART_RX_PARITY_EN adds rx_parity_err.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_ack;
`ifdef UART_RX_PARITY_EN
  logic rx_parity_err;
  modport master(output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err, input rx_ack);
  modport slave(input rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err, output rx_ack);
`else
  modport master(output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun, input rx_ack);
  modport slave(input rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun, output rx_ack);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(DIV - 1);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1 UART receiver with valid/ack handshake and LED mirror.
// Define UART_RX_PARITY_EN to insert an even-parity bit and the rx_parity_err flag.
module uart_rx_core #(
  parameter int CLK_HZ = uart_pkg::CLK_HZ,
  parameter int BAUD = uart_pkg::BAUD,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic           M_CLOCK,
  input  logic           M_RESET_N,
  input  logic           RX,
  uart_rx_core_if.master rx_if,
  output logic [7:0]     IO_LED
);
  import uart_pkg::*;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  state_t state_q, state_d;
  logic rx_meta_q, rxs_q, armed_q, armed_d, tick, ack, commit, last;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shreg_q, shreg_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, pbad_q, pbad_d;
`endif
  uart_baud_tick #(.DIV(CLK_HZ / (BAUD * OVERSAMPLE))) u_tick (
    .clk(M_CLOCK),
    .rst_n(M_RESET_N),
    .tick(tick)
  );
  always_comb begin
    ack = rx_if.rx_ack;
    last = tick && scnt_q == LAST;
    state_d = state_q;
    armed_d = armed_q | rxs_q;
    scnt_d = tick ? scnt_q + SW'(1) : scnt_q;
    bidx_d = bidx_q;
    shreg_d = shreg_q;
    commit = 1'b0;
    ferr_d = ferr_q & ~ack;
`ifdef UART_RX_PARITY_EN
    perr_d = perr_q & ~ack;
    pbad_d = pbad_q;
`endif
    case (state_q)
      IDLE: if (tick && armed_q && !rxs_q) begin
        state_d = START;
        scnt_d = '0;
      end
      START: if (tick && scnt_q == MID) begin
        state_d = rxs_q ? IDLE : DATA;
        scnt_d = '0;
        bidx_d = '0;
      end
      DATA: if (last) begin
        shreg_d[bidx_q] = rxs_q;
        bidx_d = bidx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bidx_q == 3'd7) state_d = PARITY;
`else
        if (bidx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (last) begin
        pbad_d = ^{shreg_q, rxs_q};
        perr_d = perr_d | pbad_d;
        state_d = STOP;
      end
`endif
      // Leaving disarmed means a held-low break yields a single framing error.
      STOP: if (last) begin
        state_d = IDLE;
        armed_d = 1'b0;
        ferr_d = ferr_d | ~rxs_q;
`ifdef UART_RX_PARITY_EN
        commit = rxs_q & ~pbad_q;
`else
        commit = rxs_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    data_d = commit ? shreg_q : data_q;
    valid_d = commit | (valid_q & ~ack);
    ovr_d = (ovr_q & ~ack) | (commit & valid_q & ~ack);
  end
  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) begin
      rx_meta_q <= 1'b1;
      rxs_q <= 1'b1;
      state_q <= IDLE;
      armed_q <= 1'b0;
      scnt_q <= '0;
      bidx_q <= '0;
      shreg_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
      pbad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RX;
      rxs_q <= rx_meta_q;
      state_q <= state_d;
      armed_q <= armed_d;
      scnt_q <= scnt_d;
      bidx_q <= bidx_d;
      shreg_q <= shreg_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q <= perr_d;
      pbad_q <= pbad_d;
`endif
    end
  assign rx_if.rx_data = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.rx_busy = state_q != IDLE;
  assign rx_if.rx_frame_err = ferr_q;
  assign rx_if.rx_overrun = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.rx_parity_err = perr_q;
`endif
  assign IO_LED = data_q;
endmodule
